// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline register with optional
// 2-entry skid buffer, flush-to-bubble and saturating stall counter.
module pipe_stage_reg #(
  parameter int unsigned       WIDTH  = 101,
  parameter bit                SKID   = 1'b1,
  parameter logic [WIDTH-1:0]  BUBBLE = '0,
  parameter int unsigned       CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt
);

  logic [CNT_W-1:0] stall_q;

  assign stall_cnt = stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else if (out_valid && !out_ready
                 && (stall_q != '1)) begin
      stall_q <= stall_q + CNT_W'(1);
    end
  end

  if (SKID) begin : g_skid
    typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_FULL  = 2'd1,
      S_SKID  = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic             rdy_q;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;

    assign push = in_valid & rdy_q & ~flush;
    assign pop  = (state_q != S_EMPTY) & out_ready;

    always_ff @(posedge clk) begin
      if (rst) begin
        state_q <= S_EMPTY;
        rdy_q   <= 1'b1;
      end else begin
        state_q <= state_d;
        rdy_q   <= (state_d != S_SKID);
      end
    end

    always_comb begin
      state_d = state_q;
      if (flush) begin
        state_d = S_EMPTY;
      end else begin
        unique case (state_q)
          S_EMPTY: if (push) state_d = S_FULL;
          S_FULL: begin
            if (push && !pop)
              state_d = S_SKID;
            else if (!push && pop)
              state_d = S_EMPTY;
          end
          S_SKID:  if (pop) state_d = S_FULL;
          default: state_d = S_EMPTY;
        endcase
      end
    end

    // main_q is always the head; skid_q only holds the second entry
    always_ff @(posedge clk) begin
      case (state_q)
        S_EMPTY: if (push) main_q <= in_data;
        S_FULL: begin
          if (push && pop)
            main_q <= in_data;
          else if (push)
            skid_q <= in_data;
        end
        S_SKID:  if (pop && !flush) main_q <= skid_q;
        default: ;
      endcase
    end

    always_comb begin
      out_valid = (state_q != S_EMPTY);
      out_data  = out_valid ? main_q : BUBBLE;
      occupancy = state_q;
      in_ready  = rdy_q;
    end
  end else begin : g_reg
    logic             valid_q;
    logic             push;
    logic [WIDTH-1:0] data_q;

    assign in_ready = out_ready | ~valid_q;
    assign push     = in_valid & in_ready & ~flush;

    always_ff @(posedge clk) begin
      if (rst || flush)
        valid_q <= 1'b0;
      else if (push)
        valid_q <= 1'b1;
      else if (out_ready)
        valid_q <= 1'b0;
    end

    always_ff @(posedge clk) begin
      if (push && !rst) data_q <= in_data;
    end

    assign out_valid = valid_q;
    assign out_data  = valid_q ? data_q : BUBBLE;
    assign occupancy = {1'b0, valid_q};
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed table plus randomized run against
// a queue-based reference model for three stage configurations.
module tb_pipe_stage_reg;

  logic         clk = 1'b0;
  logic         rst, flush, in_valid, out_ready;
  logic [100:0] in_data;

  logic         a_in_ready, a_out_valid;
  logic [100:0] a_out_data;
  logic [1:0]   a_occ;
  logic [15:0]  a_stall;
  logic         b_in_ready, b_out_valid;
  logic [15:0]  b_out_data;
  logic [1:0]   b_occ;
  logic [3:0]   b_stall;
  logic         c_in_ready, c_out_valid;
  logic [15:0]  c_out_data;
  logic [1:0]   c_occ;
  logic [15:0]  c_stall;

  always #5 clk = ~clk;

  pipe_stage_reg #(.WIDTH(101), .SKID(1'b1), .CNT_W(16)) u_a (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(a_in_ready),
    .in_data(in_data),
    .out_valid(a_out_valid), .out_ready(out_ready),
    .out_data(a_out_data), .occupancy(a_occ),
    .stall_cnt(a_stall));

  pipe_stage_reg #(.WIDTH(16), .SKID(1'b1),
                   .BUBBLE(16'hB0B0), .CNT_W(4)) u_b (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(b_in_ready),
    .in_data(in_data[15:0]),
    .out_valid(b_out_valid), .out_ready(out_ready),
    .out_data(b_out_data), .occupancy(b_occ),
    .stall_cnt(b_stall));

  pipe_stage_reg #(.WIDTH(16), .SKID(1'b0),
                   .BUBBLE(16'hB0B0), .CNT_W(16)) u_c (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(c_in_ready),
    .in_data(in_data[15:0]),
    .out_valid(c_out_valid), .out_ready(out_ready),
    .out_data(c_out_data), .occupancy(c_occ),
    .stall_cnt(c_stall));

  // reference: a FIFO of capacity 2 (skid) or 1 (plain)
  logic [100:0] q[$];
  logic [100:0] qc[$];
  int ca = 0, cb = 0, cc = 0;

  always @(posedge clk) begin : model
    bit va, ra, vc, rc;
    va = q.size() > 0;
    ra = q.size() < 2;
    vc = qc.size() > 0;
    rc = (qc.size() == 0) || out_ready;
    if (rst) begin
      q.delete(); qc.delete();
      ca = 0; cb = 0; cc = 0;
    end else begin
      if (va && !out_ready) begin
        if (ca < 65535) ca = ca + 1;
        if (cb < 15) cb = cb + 1;
      end
      if (vc && !out_ready && cc < 65535) cc = cc + 1;
      if (flush) begin
        q.delete(); qc.delete();
      end else begin
        if (va && out_ready) void'(q.pop_front());
        if (in_valid && ra) q.push_back(in_data);
        if (vc && out_ready) void'(qc.pop_front());
        if (in_valid && rc) qc.push_back(in_data);
      end
    end
  end

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_all();
    logic [100:0] ea;
    logic [15:0]  eb, ec;
    int           sa, sc;
    sa = q.size();
    sc = qc.size();
    ea = (sa > 0) ? q[0] : '0;
    eb = (sa > 0) ? q[0][15:0] : 16'hB0B0;
    ec = (sc > 0) ? qc[0][15:0] : 16'hB0B0;
    chk("a_valid", 128'(a_out_valid), 128'(sa > 0));
    chk("a_data", 128'(a_out_data), 128'(ea));
    chk("a_occ", 128'(a_occ), 128'(sa));
    chk("a_rdy", 128'(a_in_ready), 128'(sa < 2));
    chk("a_stall", 128'(a_stall), 128'(ca));
    chk("b_data", 128'(b_out_data), 128'(eb));
    chk("b_occ", 128'(b_occ), 128'(sa));
    chk("b_rdy", 128'(b_in_ready), 128'(sa < 2));
    chk("b_stall", 128'(b_stall), 128'(cb));
    chk("c_valid", 128'(c_out_valid), 128'(sc > 0));
    chk("c_data", 128'(c_out_data), 128'(ec));
    chk("c_occ", 128'(c_occ), 128'(sc));
    chk("c_rdy", 128'(c_in_ready),
        128'((sc == 0) || out_ready));
    chk("c_stall", 128'(c_stall), 128'(cc));
  endtask

  task automatic drive(input bit r, input bit f,
                       input bit iv, input logic [15:0] id,
                       input bit ordy);
    rst = r; flush = f; in_valid = iv;
    in_data = 101'(id); out_ready = ordy;
  endtask

  task automatic step();
    @(negedge clk);
    check_all();
  endtask

  typedef struct {
    bit rst, flush, iv;
    logic [15:0] id;
    bit ordy, ev;
    logic [15:0] ed;
    int eocc;
    bit erdy;
    int ecnt;
  } vec_t;

  vec_t vt[$];

  function automatic void add(bit r, bit f, bit iv,
      logic [15:0] id, bit ordy, bit ev, logic [15:0] ed,
      int eocc, bit erdy, int ecnt);
    vt.push_back('{r, f, iv, id, ordy, ev, ed,
                   eocc, erdy, ecnt});
  endfunction

  initial begin
    logic [127:0] rnd;
    add(1,0,1,16'hDEAD,0, 0,0,0,1,0);
    add(1,0,1,16'hDEAD,0, 0,0,0,1,0);
    for (int k = 0; k < 8; k++)
      add(0,0,1,16'(k),1, 1,16'(k),1,1,0);
    add(0,0,0,0,1, 0,0,0,1,0);
    add(0,0,1,16'hA,0, 1,16'hA,1,1,0);
    add(0,0,1,16'hB,0, 1,16'hA,2,0,1);
    add(0,0,0,0,0, 1,16'hA,2,0,2);
    add(0,0,0,0,0, 1,16'hA,2,0,3);
    add(0,0,0,0,0, 1,16'hA,2,0,4);
    add(0,0,0,0,1, 1,16'hB,1,1,4);
    add(0,0,0,0,1, 0,0,0,1,4);
    add(0,0,1,16'h11,0, 1,16'h11,1,1,4);
    add(0,0,1,16'h22,0, 1,16'h11,2,0,5);
    add(0,1,1,16'hCC,0, 0,0,0,1,6);
    add(0,0,1,16'hDD,0, 1,16'hDD,1,1,6);
    add(0,0,0,0,1, 0,0,0,1,6);
    add(0,1,1,16'hEE,1, 0,0,0,1,6);
    add(0,0,0,0,1, 0,0,0,1,6);
    add(1,0,0,0,0, 0,0,0,1,0);

    foreach (vt[i]) begin
      drive(vt[i].rst, vt[i].flush, vt[i].iv,
            vt[i].id, vt[i].ordy);
      @(negedge clk);
      chk($sformatf("t%0d_valid", i),
          128'(a_out_valid), 128'(vt[i].ev));
      chk($sformatf("t%0d_data", i),
          128'(a_out_data), 128'(vt[i].ed));
      chk($sformatf("t%0d_occ", i),
          128'(a_occ), 128'(vt[i].eocc));
      chk($sformatf("t%0d_rdy", i),
          128'(a_in_ready), 128'(vt[i].erdy));
      chk($sformatf("t%0d_stall", i),
          128'(a_stall), 128'(vt[i].ecnt));
      check_all();
    end

    // saturating counter on the CNT_W=4 instance
    drive(1,0,0,0,0); step();
    drive(0,0,1,16'h55,0); step();
    drive(0,0,0,0,0);
    for (int k = 0; k < 20; k++) step();
    chk("b_sat", 128'(b_stall), 128'(15));
    step();
    chk("b_sat_hold", 128'(b_stall), 128'(15));
    drive(1,0,0,0,0); step();
    chk("b_sat_rst", 128'(b_stall), 128'(0));

    // combinational ready on the SKID=0 instance
    drive(0,0,1,16'hE1,0); step();
    drive(0,0,1,16'hE2,1);
    #1 chk("c_rdy_comb", 128'(c_in_ready), 128'(1));
    step();
    chk("c_data_e2", 128'(c_out_data), 128'(16'hE2));
    drive(0,0,1,16'hE3,0);
    #1 chk("c_rdy_block", 128'(c_in_ready), 128'(0));
    step();
    chk("c_data_held", 128'(c_out_data), 128'(16'hE2));

    for (int k = 0; k < 3000; k++) begin
      rnd = {$urandom, $urandom, $urandom, $urandom};
      rst       = ($urandom_range(0, 99) < 2);
      flush     = ($urandom_range(0, 15) == 0);
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 9) < 6);
      in_data   = rnd[100:0];
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
